// File: rtl/aes256_cbc_pkcs7_framer.sv
// aes256_cbc_pkcs7_framer: frames key, IV and message bytes for an AES-256 CBC core, adding PKCS#7 padding on encrypt.
// Ports: Clk/Rst (sync, active-high); S_* upstream AXI-Stream byte input (S_tuser = mode, 1=encrypt);
// M_* registered downstream byte output (M_tuser = latched mode, M_tkeep = M_tvalid);
// Len_err pulses one cycle when a decrypt message is not a whole number of 16-byte blocks.
module aes256_cbc_pkcs7_framer #(
  parameter int KEY_BYTES = 32,
  parameter int IV_BYTES  = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] S_tdata,
  input  logic       S_tvalid,
  output logic       S_tready,
  input  logic       S_tlast,
  input  logic       S_tuser,
  output logic [7:0] M_tdata,
  output logic       M_tvalid,
  input  logic       M_tready,
  output logic       M_tlast,
  output logic       M_tuser,
  output logic       M_tkeep,
  output logic       Len_err
);
  typedef enum logic [1:0] {ST_KEY, ST_IV, ST_DATA, ST_PAD} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  blk_cnt_q, blk_cnt_d;
  logic [4:0]  pad_val_q, pad_val_d, pad_cnt_q, pad_cnt_d;
  logic        mode_q, mode_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d, m_tuser_q, m_tuser_d;
  logic        len_err_q, len_err_d;
  logic        out_free, s_acc;
  // The output register can take a new byte when empty or when its byte leaves this cycle.
  assign out_free = !m_tvalid_q || M_tready;
  assign S_tready = !Rst && state_q != ST_PAD && out_free;
  assign s_acc    = S_tvalid && S_tready;
  assign M_tdata  = m_tdata_q;
  assign M_tvalid = m_tvalid_q;
  assign M_tlast  = m_tlast_q;
  assign M_tuser  = m_tuser_q;
  assign M_tkeep  = m_tvalid_q;
  assign Len_err  = len_err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_cnt_d  = blk_cnt_q;
    pad_val_d  = pad_val_q;
    pad_cnt_d  = pad_cnt_q;
    mode_d     = mode_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = out_free ? 1'b0 : m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    len_err_d  = 1'b0;
    if (s_acc) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = S_tdata;
      m_tlast_d  = 1'b0;
      m_tuser_d  = mode_q;
      case (state_q)
        ST_KEY: begin
          // Mode is taken from the first key byte and applies to its own output byte too.
          if (cnt_q == 16'd0) begin
            mode_d    = S_tuser;
            m_tuser_d = S_tuser;
          end
          cnt_d   = (cnt_q == 16'(KEY_BYTES - 1)) ? 16'd0 : cnt_q + 16'd1;
          state_d = (cnt_q == 16'(KEY_BYTES - 1)) ? ST_IV : ST_KEY;
        end
        ST_IV: begin
          cnt_d   = (cnt_q == 16'(IV_BYTES - 1)) ? 16'd0 : cnt_q + 16'd1;
          state_d = (cnt_q == 16'(IV_BYTES - 1)) ? ST_DATA : ST_IV;
        end
        ST_DATA: begin
          blk_cnt_d = blk_cnt_q + 4'd1;
          if (S_tlast) begin
            blk_cnt_d = 4'd0;
            if (mode_q) begin
              // The 4-bit sum wraps to 0 on an aligned message, giving a full 16-byte pad block.
              pad_val_d = 5'd16 - {1'b0, blk_cnt_q + 4'd1};
              pad_cnt_d = 5'd16 - {1'b0, blk_cnt_q + 4'd1};
              state_d   = ST_PAD;
            end else begin
              m_tlast_d = 1'b1;
              len_err_d = blk_cnt_q != 4'hF;
              state_d   = ST_KEY;
            end
          end
        end
        default: ;
      endcase
    end else if (state_q == ST_PAD && out_free) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = {3'b000, pad_val_q};
      m_tlast_d  = pad_cnt_q == 5'd1;
      m_tuser_d  = mode_q;
      pad_cnt_d  = pad_cnt_q - 5'd1;
      state_d    = (pad_cnt_q == 5'd1) ? ST_KEY : ST_PAD;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_KEY;
      cnt_q      <= '0;
      blk_cnt_q  <= '0;
      pad_val_q  <= '0;
      pad_cnt_q  <= '0;
      mode_q     <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      pad_val_q  <= pad_val_d;
      pad_cnt_q  <= pad_cnt_d;
      mode_q     <= mode_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      len_err_q  <= len_err_d;
    end
  end
endmodule

// File: tb/tb_aes256_cbc_pkcs7_framer.sv
// tb_aes256_cbc_pkcs7_framer: randomized bench for the CBC/PKCS#7 framer against a queue-based frame model.
module tb_aes256_cbc_pkcs7_framer;
  localparam int KB = 32;
  localparam int IB = 16;
  logic       Clk = 1'b0, Rst = 1'b1;
  logic [7:0] S_tdata = '0, M_tdata;
  logic       S_tvalid = 1'b0, S_tready, S_tlast = 1'b0, S_tuser = 1'b0;
  logic       M_tvalid, M_tready = 1'b0, M_tlast, M_tuser, M_tkeep, Len_err;
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  beat_t in_q[$], exp_q[$];
  int vectors = 0, errors = 0, exp_lenerr = 0;
  aes256_cbc_pkcs7_framer #(.KEY_BYTES(KB), .IV_BYTES(IB)) dut (
    .Clk(Clk), .Rst(Rst),
    .S_tdata(S_tdata), .S_tvalid(S_tvalid), .S_tready(S_tready), .S_tlast(S_tlast), .S_tuser(S_tuser),
    .M_tdata(M_tdata), .M_tvalid(M_tvalid), .M_tready(M_tready), .M_tlast(M_tlast), .M_tuser(M_tuser),
    .M_tkeep(M_tkeep), .Len_err(Len_err)
  );
  always #5 Clk = ~Clk;
  // Model: key and IV pass through, message passes through, encrypt appends 16-(L mod 16) bytes of that value.
  function automatic void add_msg(bit enc, int len, bit incr);
    int pad;
    for (int i = 0; i < KB + IB; i++) begin
      beat_t b;
      b.d = 8'($urandom);
      b.l = 1'($urandom);
      b.u = (i == 0) ? enc : 1'($urandom);
      in_q.push_back(b);
      exp_q.push_back('{b.d, 1'b0, enc});
    end
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = incr ? 8'(i + 1) : 8'($urandom);
      b.l = (i == len - 1);
      b.u = 1'($urandom);
      in_q.push_back(b);
      exp_q.push_back('{b.d, !enc && i == len - 1, enc});
    end
    if (enc) begin
      pad = 16 - (len % 16);
      for (int j = 0; j < pad; j++) exp_q.push_back('{8'(pad), j == pad - 1, enc});
    end else if (len % 16 != 0) exp_lenerr++;
  endfunction
  function automatic void clear_model();
    in_q.delete();
    exp_q.delete();
    exp_lenerr = 0;
  endfunction
  task automatic do_reset(string tag);
    @(negedge Clk);
    Rst = 1'b1;
    S_tvalid = 1'b0;
    M_tready = 1'b0;
    #1;
    vectors++;
    if (S_tready !== 1'b0) begin
      errors++;
      $display("FAIL %s_tready_in_reset: got %b expected 0", tag, S_tready);
    end
    @(negedge Clk);
    vectors++;
    if ({M_tvalid, M_tdata, M_tlast, M_tuser, M_tkeep, Len_err, S_tready} !== 14'd0) begin
      errors++;
      $display("FAIL %s_reset_outputs: got v=%b d=%h l=%b u=%b k=%b e=%b r=%b expected all 0",
               tag, M_tvalid, M_tdata, M_tlast, M_tuser, M_tkeep, Len_err, S_tready);
    end
    Rst = 1'b0;
  endtask
  task automatic run_stream(string tag, int rdy_pct, int vld_pct, int abort_after, bit gapless);
    int in_idx = 0, out_idx = 0, tail = 0, lenerr_seen = 0, idle = 0, cyc = 0;
    bit stalled = 1'b0;
    beat_t held = '0, cur;
    while (cyc < 20000) begin
      @(negedge Clk);
      M_tready = ($urandom_range(99) < rdy_pct);
      if (in_idx < in_q.size() && $urandom_range(99) < vld_pct) begin
        S_tvalid = 1'b1;
        {S_tdata, S_tlast, S_tuser} = in_q[in_idx];
      end else S_tvalid = 1'b0;
      #1;
      cur = '{M_tdata, M_tlast, M_tuser};
      if (stalled) begin
        vectors++;
        if (M_tvalid !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL %s_stall_hold: got v=%b beat=%h expected v=1 beat=%h", tag, M_tvalid, cur, held);
        end
      end
      if (Len_err === 1'b1) lenerr_seen++;
      if (M_tvalid !== 1'b1 && out_idx > 0 && out_idx < exp_q.size()) idle++;
      if (M_tvalid === 1'b1 && M_tready) begin
        vectors++;
        if (out_idx >= exp_q.size()) begin
          errors++;
          $display("FAIL %s_extra_byte: got beat=%h expected none", tag, cur);
        end else if (cur !== exp_q[out_idx] || M_tkeep !== 1'b1) begin
          errors++;
          $display("FAIL %s_byte[%0d]: got beat=%h keep=%b expected beat=%h keep=1",
                   tag, out_idx, cur, M_tkeep, exp_q[out_idx]);
        end
        out_idx++;
      end
      stalled = M_tvalid === 1'b1 && !M_tready;
      held = cur;
      if (S_tvalid && S_tready) in_idx++;
      if (abort_after >= 0 && in_idx == abort_after) return;
      cyc++;
      if (in_idx == in_q.size() && out_idx >= exp_q.size()) tail++;
      if (tail == 4) break;
    end
    S_tvalid = 1'b0;
    vectors++;
    if (out_idx != exp_q.size()) begin
      errors++;
      $display("FAIL %s_byte_count: got %0d expected %0d", tag, out_idx, exp_q.size());
    end
    vectors++;
    if (lenerr_seen != exp_lenerr) begin
      errors++;
      $display("FAIL %s_len_err_cycles: got %0d expected %0d", tag, lenerr_seen, exp_lenerr);
    end
    if (gapless) begin
      vectors++;
      if (idle != 0) begin
        errors++;
        $display("FAIL %s_idle_cycles: got %0d expected 0", tag, idle);
      end
    end
  endtask
  task automatic test_reset();
    do_reset("init");
  endtask
  task automatic test_encrypt_short();
    clear_model();
    add_msg(1'b1, 5, 1'b1);
    run_stream("enc5", 100, 100, -1, 1'b1);
  endtask
  task automatic test_encrypt_aligned();
    clear_model();
    add_msg(1'b1, 16, 1'b0);
    run_stream("enc16", 100, 100, -1, 1'b1);
  endtask
  task automatic test_decrypt_aligned();
    clear_model();
    add_msg(1'b0, 32, 1'b0);
    run_stream("dec32", 100, 100, -1, 1'b1);
  endtask
  task automatic test_decrypt_misaligned();
    clear_model();
    add_msg(1'b0, 20, 1'b0);
    run_stream("dec20", 100, 100, -1, 1'b1);
  endtask
  task automatic test_backpressure();
    clear_model();
    add_msg(1'b1, 5, 1'b1);
    run_stream("bp", 50, 80, -1, 1'b0);
  endtask
  task automatic test_reset_mid_message();
    clear_model();
    add_msg(1'b1, 5, 1'b1);
    run_stream("abort", 100, 100, 10, 1'b0);
    do_reset("mid");
    clear_model();
    add_msg(1'b1, 5, 1'b1);
    run_stream("after_rst", 100, 100, -1, 1'b1);
  endtask
  task automatic test_back_to_back();
    clear_model();
    add_msg(1'b1, 15, 1'b0);
    add_msg(1'b0, 7, 1'b0);
    for (int i = 0; i < 3; i++) add_msg(1'($urandom), $urandom_range(1, 40), 1'b0);
    run_stream("b2b", 100, 100, -1, 1'b1);
  endtask
  task automatic test_random_traffic();
    clear_model();
    for (int i = 0; i < 6; i++) add_msg(1'($urandom), $urandom_range(1, 48), 1'b0);
    run_stream("rand", 60, 70, -1, 1'b0);
  endtask
  initial begin
    test_reset();
    test_encrypt_short();
    test_encrypt_aligned();
    test_decrypt_aligned();
    test_decrypt_misaligned();
    test_backpressure();
    test_reset_mid_message();
    test_back_to_back();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
